// File: rtl/regfile_pkg.sv
// Shared definitions for the decode-stage register file and its
// pending-write scoreboard: default geometry and width helpers.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;

    // Width able to index n items; never below one bit.
    function automatic int clog2_safe(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

    // Width of a counter that must hold every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return clog2_safe(max_val + 32'sd1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// ID-stage bus of the register file: read ports, issue handshake,
// write-back, flush and the hazard outputs.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = clog2_safe(NUM_REGS_DEF),
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_dst;
    logic                     iss_ready;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic                     stall;
    logic                     sb_err;

    modport master (
        output rd_en, rd_addr, iss_valid, iss_dst, wb_en, wb_addr, wb_data, flush,
        input  rd_data, rd_busy, iss_ready, stall, sb_err
    );

    modport slave (
        input  rd_en, rd_addr, iss_valid, iss_dst, wb_en, wb_addr, wb_data, flush,
        output rd_data, rd_busy, iss_ready, stall, sb_err
    );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating up/down counter tracking outstanding writes to one register.
// Simultaneous inc and dec cancel; clr wins over both.
module sb_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating step up, or floored step down.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && !dec && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == W'(MAX));
    assign zero = (cnt_q == {W{1'b0}});
endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: combinational read ports with write-back
// bypass, plus per-register pending-write counters driving stall.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int MAX_PEND = 3,
    parameter int ZERO_REG = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int ADDR_W = clog2_safe(NUM_REGS);
    localparam int PEND_W = cnt_width(MAX_PEND);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        regs_d [NUM_REGS];
    logic                     sb_err_q;
    logic                     sb_err_d;
    logic [PEND_W-1:0]        pend_s [NUM_REGS];
    logic [NUM_REGS-1:0]      full_s;
    logic [NUM_REGS-1:0]      zero_s;
    logic [NUM_REGS-1:0]      inc_s;
    logic [NUM_REGS-1:0]      dec_s;
    logic [ADDR_W-1:0]        port_addr_s [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_s;
    logic [NUM_RD-1:0]        rd_busy_s;
    logic                     wr_ok_s;
    logic                     wb_tracked_s;
    logic                     iss_ready_s;

    // Write-back qualification, issue acceptance and error detection.
    always_comb begin
        wr_ok_s      = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == ADDR_W'(0)));
        wb_tracked_s = !zero_s[bus.wb_addr];
        // A full destination still accepts when this cycle's write-back retires one.
        iss_ready_s  = !(full_s[bus.iss_dst] &&
                         !(wr_ok_s && wb_tracked_s && (bus.wb_addr == bus.iss_dst)));
        if (wr_ok_s && !wb_tracked_s && !bus.flush) begin
            sb_err_d = 1'b1;
        end else begin
            sb_err_d = sb_err_q;
        end
    end

    // Array next state.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok_s) begin
            regs_d[bus.wb_addr] = bus.wb_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register array and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= {DATA_W{1'b0}};
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sb_err_q <= sb_err_d;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        localparam bit IS_ZERO = (ZERO_REG != 0) && (r == 0);
        assign inc_s[r] = bus.iss_valid && iss_ready_s && (bus.iss_dst == ADDR_W'(r)) && !IS_ZERO;
        assign dec_s[r] = wr_ok_s && (bus.wb_addr == ADDR_W'(r)) && !zero_s[r];

        sb_counter #(.MAX(MAX_PEND), .W(PEND_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc_s[r]),
            .dec  (dec_s[r]),
            .clr  (bus.flush),
            .cnt  (pend_s[r]),
            .full (full_s[r]),
            .zero (zero_s[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        assign port_addr_s[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end

    // Read muxes; a bypass hit hides one pending write from the busy test.
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_s = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            if ((ZERO_REG != 0) && (port_addr_s[i] == ADDR_W'(0))) begin
                rd_data_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy_s[i]                  = 1'b0;
            end else if (wr_ok_s && (bus.wb_addr == port_addr_s[i])) begin
                rd_data_s[i*DATA_W +: DATA_W] = bus.wb_data;
                rd_busy_s[i]                  = (pend_s[port_addr_s[i]] > PEND_W'(1));
            end else begin
                rd_data_s[i*DATA_W +: DATA_W] = regs_q[port_addr_s[i]];
                rd_busy_s[i]                  = (pend_s[port_addr_s[i]] != PEND_W'(0));
            end
        end
    end

    assign bus.rd_data   = rd_data_s;
    assign bus.rd_busy   = rd_busy_s;
    assign bus.iss_ready = iss_ready_s;
    assign bus.sb_err    = sb_err_q;
    assign bus.stall     = (|(bus.rd_en & rd_busy_s)) | (bus.iss_valid & ~iss_ready_s);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a default instance and a ZERO_REG=1, three-port instance
// share one stimulus stream and are compared against an array-based model.
module tb_regfile_scoreboard;

    localparam int MAXP = 3;

    typedef struct packed {
        logic            rst_lo;
        logic            rst_mid;
        logic [2:0]      rd_en;
        logic [2:0][2:0] rd_addr;
        logic            iss_valid;
        logic [2:0]      iss_dst;
        logic            wb_en;
        logic [2:0]      wb_addr;
        logic [15:0]     wb_data;
        logic            flush;
    } stim_t;

    typedef struct packed {
        logic [5:0][15:0] data;
        logic [5:0]       busy;
        logic [1:0]       ready;
        logic [1:0]       stall;
        logic [1:0]       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [15:0] m_regs [2][8];
    int          m_pend [2][8];
    bit          m_err  [2];

    regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) if0 ();
    regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) if1 ();

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .MAX_PEND(3), .ZERO_REG(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .MAX_PEND(3), .ZERO_REG(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input int p,
                         input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h at %0t", name, d, p, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 8; r++) begin
                m_regs[d][r] = 16'h0000;
                m_pend[d][r] = 0;
            end
            m_err[d] = 1'b0;
        end
    endtask

    // Outputs follow from the current model state; then the edge is applied.
    task automatic predict(input stim_t s, input bit adv, output exp_t e);
        e = '0;
        for (int d = 0; d < 2; d++) begin
            bit zr;
            bit ign;
            bit wr;
            bit dec_ok;
            bit rdy;
            bit st;
            bit hit;
            bit bsy;
            int nrd;
            int a;
            logic [15:0] dat;
            zr     = (d == 1);
            nrd    = (d == 1) ? 3 : 2;
            ign    = zr && (s.wb_addr == 3'd0);
            wr     = s.wb_en && !ign;
            dec_ok = wr && (m_pend[d][s.wb_addr] > 0);
            rdy    = !((m_pend[d][s.iss_dst] == MAXP) && !(dec_ok && (s.wb_addr == s.iss_dst)));
            st     = s.iss_valid && !rdy;
            for (int p = 0; p < nrd; p++) begin
                a   = int'(s.rd_addr[p]);
                hit = wr && (int'(s.wb_addr) == a);
                if (zr && (a == 0)) begin
                    dat = 16'h0000;
                    bsy = 1'b0;
                end else begin
                    dat = hit ? s.wb_data : m_regs[d][a];
                    bsy = m_pend[d][a] > (hit ? 1 : 0);
                end
                e.data[d*3+p] = dat;
                e.busy[d*3+p] = bsy;
                if (s.rd_en[p] && bsy) st = 1'b1;
            end
            e.ready[d] = rdy;
            e.stall[d] = st;
            e.err[d]   = m_err[d];
            if (adv) begin
                if (wr) begin
                    m_regs[d][s.wb_addr] = s.wb_data;
                    if (!s.flush && (m_pend[d][s.wb_addr] == 0)) m_err[d] = 1'b1;
                end
                if (s.flush) begin
                    for (int r = 0; r < 8; r++) m_pend[d][r] = 0;
                end else begin
                    if (s.iss_valid && rdy && !(zr && (s.iss_dst == 3'd0)))
                        m_pend[d][s.iss_dst] = m_pend[d][s.iss_dst] + 1;
                    if (dec_ok)
                        m_pend[d][s.wb_addr] = m_pend[d][s.wb_addr] - 1;
                end
            end
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n         = s.rst_lo ? 1'b0 : 1'b1;
        if0.rd_en     = s.rd_en[1:0];
        if0.rd_addr   = s.rd_addr[1:0];
        if1.rd_en     = s.rd_en;
        if1.rd_addr   = s.rd_addr;
        if0.iss_valid = s.iss_valid;  if1.iss_valid = s.iss_valid;
        if0.iss_dst   = s.iss_dst;    if1.iss_dst   = s.iss_dst;
        if0.wb_en     = s.wb_en;      if1.wb_en     = s.wb_en;
        if0.wb_addr   = s.wb_addr;    if1.wb_addr   = s.wb_addr;
        if0.wb_data   = s.wb_data;    if1.wb_data   = s.wb_data;
        if0.flush     = s.flush;      if1.flush     = s.flush;
        if (s.rst_mid) begin
            #1;
            rst_n = 1'b0;
        end
        if (s.rst_lo || s.rst_mid) model_reset();
        predict(s, !(s.rst_lo || s.rst_mid), e);
        exp_q.push_back(e);
    endtask

    // Monitor: compare settled outputs against the oldest expectation.
    always @(negedge clk) begin
        #3;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int p = 0; p < 2; p++) begin
                check("rd_data", 0, p, if0.rd_data[p*16 +: 16], mon_e.data[p]);
                check("rd_busy", 0, p, 16'(if0.rd_busy[p]), 16'(mon_e.busy[p]));
            end
            for (int p = 0; p < 3; p++) begin
                check("rd_data", 1, p, if1.rd_data[p*16 +: 16], mon_e.data[3+p]);
                check("rd_busy", 1, p, 16'(if1.rd_busy[p]), 16'(mon_e.busy[3+p]));
            end
            check("iss_ready", 0, 0, 16'(if0.iss_ready), 16'(mon_e.ready[0]));
            check("iss_ready", 1, 0, 16'(if1.iss_ready), 16'(mon_e.ready[1]));
            check("stall", 0, 0, 16'(if0.stall), 16'(mon_e.stall[0]));
            check("stall", 1, 0, 16'(if1.stall), 16'(mon_e.stall[1]));
            check("sb_err", 0, 0, 16'(if0.sb_err), 16'(mon_e.err[0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        stim_t s;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        model_reset();

        s = '0; s.rst_lo = 1'b1;                                      step(s);
        // Issue then write back r3, read it next cycle.
        s = '0; s.iss_valid = 1'b1; s.iss_dst = 3'd3;                 step(s);
        s = '0; s.wb_en = 1'b1; s.wb_addr = 3'd3; s.wb_data = 16'hBEEF; step(s);
        s = '0; s.rd_en = 3'b001; s.rd_addr[0] = 3'd3;                step(s);
        // Same-cycle bypass on port 1.
        s = '0; s.iss_valid = 1'b1; s.iss_dst = 3'd5;                 step(s);
        s = '0; s.wb_en = 1'b1; s.wb_addr = 3'd5; s.wb_data = 16'h1234;
        s.rd_en = 3'b010; s.rd_addr[1] = 3'd5;                        step(s);
        s = '0; s.rd_addr[1] = 3'd5;                                  step(s);
        // RAW hazard on r2, cleared by the satisfying write-back.
        s = '0; s.iss_valid = 1'b1; s.iss_dst = 3'd2;                 step(s);
        s = '0; s.rd_en = 3'b001; s.rd_addr[0] = 3'd2;                step(s);
        s.wb_en = 1'b1; s.wb_addr = 3'd2; s.wb_data = 16'h00AA;       step(s);
        // Saturation of r4, then full issue rescued by a write-back.
        s = '0; s.iss_valid = 1'b1; s.iss_dst = 3'd4;
        repeat (4) step(s);
        s.wb_en = 1'b1; s.wb_addr = 3'd4; s.wb_data = 16'h4444;       step(s);
        s = '0; s.rd_en = 3'b001; s.rd_addr[0] = 3'd4;                step(s);
        // Flush with concurrent write-back, then an unmatched write-back.
        s = '0; s.iss_valid = 1'b1; s.iss_dst = 3'd1;
        repeat (2) step(s);
        s = '0; s.flush = 1'b1; s.wb_en = 1'b1; s.wb_addr = 3'd1; s.wb_data = 16'h0055;
        s.rd_addr[0] = 3'd1;                                          step(s);
        s = '0; s.wb_en = 1'b1; s.wb_addr = 3'd1; s.wb_data = 16'h0066; step(s);
        s = '0; s.rd_addr[0] = 3'd1;
        repeat (2) step(s);
        // Register 0 write and issue on both instances.
        s = '0; s.wb_en = 1'b1; s.wb_addr = 3'd0; s.wb_data = 16'hFFFF;
        s.iss_valid = 1'b1; s.iss_dst = 3'd0; s.rd_en = 3'b111;       step(s);
        s = '0; s.rd_en = 3'b111;                                     step(s);
        // Asynchronous reset between edges.
        s = '0; s.rd_en = 3'b001; s.rd_addr[0] = 3'd3; s.rd_addr[1] = 3'd5;
        s.rst_mid = 1'b1;                                             step(s);
        s.rst_mid = 1'b0; s.rst_lo = 1'b1;                            step(s);

        for (int n = 0; n < 400; n++) begin
            s           = '0;
            s.rd_en     = 3'($urandom);
            s.rd_addr[0] = 3'($urandom_range(0, 7));
            s.rd_addr[1] = 3'($urandom_range(0, 7));
            s.rd_addr[2] = 3'($urandom_range(0, 7));
            s.iss_valid = ($urandom_range(0, 99) < 45);
            s.iss_dst   = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            s.wb_en     = ($urandom_range(0, 99) < 40);
            s.wb_addr   = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            s.wb_data   = 16'($urandom);
            s.flush     = ($urandom_range(0, 99) < 3);
            step(s);
        end

        repeat (2) @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised decode-stage register file with N combinational read ports, one write-back port with same-cycle bypass, and a per-register pending-write scoreboard.
- Sits in the ID stage. Read addresses come from the IF/ID buffer; write-back comes from the MEM/WB buffer.
- Drives read data into the ID/EX buffer and a stall request to the hazard/fetch logic.
- Generalises the fixed 8x16-bit, two-read register file with read-after-write (RAW) hazard tracking and an optional hardwired zero register.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of architectural registers (power of two, >=2)
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override)
- NUM_RD, 2, number of read ports (1..4)
- MAX_PEND, 3, maximum outstanding writes per register (1..7)
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes and issues

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read valid (used only for stall)
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  per-port pending-write indicator
- iss_valid  in  1  decoded instruction will write iss_dst
- iss_dst  in  ADDR_W  destination register of the issuing instruction
- iss_ready  out  1  scoreboard can accept the issue this cycle
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back address
- wb_data  in  DATA_W  write-back data
- flush  in  1  synchronous squash of all pending counts
- stall  out  1  hold IF/ID and insert bubble
- sb_err  out  1  sticky: write-back to a register with zero pending count

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous and active-low. On assertion, all registers, all pending counters and sb_err are cleared to 0 immediately.
  - Deassertion is synchronised externally.
- Storage:
  - Register array is NUM_REGS x DATA_W.
  - The write happens on the rising edge when wb_en=1, except when ZERO_REG=1 and wb_addr=0.
- Reads (combinational):
  - rd_data[i] = wb_data when wb_en && wb_addr==rd_addr[i] and the write is not suppressed (write-through bypass). Otherwise rd_data[i] = regs[rd_addr[i]].
  - When ZERO_REG=1 and rd_addr[i]=0, rd_data[i]=0.
  - All ports are independent; identical addresses return identical data.
- Scoreboard:
  - pend[r] is a counter of width $clog2(MAX_PEND+1).
  - inc = iss_valid && iss_ready (never for r0 when ZERO_REG=1). dec = wb_en && pend[wb_addr]!=0.
  - Same register, inc and dec in the same cycle: count unchanged.
  - Different registers: both update.
  - iss_ready = 0 when pend[iss_dst]==MAX_PEND and no dec targets iss_dst this cycle; otherwise 1. Counters never wrap.
  - Write-back with pend[wb_addr]==0 and wb_en=1: data is still written, count stays 0, and sb_err is set to 1 next edge. sb_err clears only on reset.
- Busy and stall:
  - rd_busy[i] = pend[rd_addr[i]] > (bypass hit on port i ? 1 : 0). A write-back satisfying the last pending write therefore clears the hazard in the same cycle.
  - rd_busy[i] = 0 for r0 when ZERO_REG=1.
  - stall = |(rd_en & rd_busy) | (iss_valid & ~iss_ready). Combinational, no registered latency.
  - The caller must deassert iss_valid while stall=1. If it does not, inc still follows iss_ready only.
- Flush:
  - On flush=1 at an edge, all pend counters clear to 0 and the same-cycle inc is discarded.
  - A same-cycle write-back still writes data and does not set sb_err.
  - Register contents are unaffected.
- Latency:
  - A write is visible to reads in the same cycle via bypass, and from the array in the next cycle.
  - Scoreboard updates are visible one cycle after the edge.

Decomposition:
- Shared package regfile_pkg:
  - function clog2_safe (returns >=1)
  - localparams for default widths (DATA_W_DEF=16, NUM_REGS_DEF=8)
  - packed-port slice helper macros or functions
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, clr and MAX parameter, generating full and zero outputs. Instantiate it NUM_REGS times in a generate loop.
- Read muxes and bypass stay in the top level.

Test Plan:
- Reset with defaults; write r3=0xBEEF via wb; next cycle read port0 r3 -> rd_data0=0xBEEF, rd_busy0=0, stall=0, sb_err=0.
- Bypass: wb_en=1, wb_addr=5, wb_data=0x1234 while rd_addr1=5 in the same cycle -> rd_data1=0x1234 combinationally; array holds 0x1234 after the edge.
- RAW hazard: issue r2 (pend=1); next cycle rd_en0=1, rd_addr0=2 -> rd_busy0=1, stall=1. Then wb r2=0x00AA -> rd_busy0=0, stall=0 in that cycle, rd_data0=0x00AA.
- Saturation: three issues to r4 (MAX_PEND=3) then a fourth -> iss_ready=0, stall=1, pend stays 3. Repeat the fourth issue with a simultaneous wb to r4 -> iss_ready=1, pend stays 3.
- Flush and error: pend r1=2; assert flush with a concurrent wb to r1 -> pend=0, sb_err=0, data written. Then wb r1 again -> sb_err=1 and stays 1 until rst_n=0.
- ZERO_REG=1, NUM_RD=3: wb r0=0xFFFF and issue to r0 -> all three ports read r0 as 0, rd_busy=0, iss_ready=1, pend[0] stays 0.
- Async reset mid-operation: assert rst_n=0 between clock edges -> outputs clear immediately without waiting for clk.
